// File: rtl/alu_exec_unit.sv
// rtl/alu_exec_unit.sv - execute-stage ALU with valid/ready handshakes and an iterative or barrel shifter
// Optional feature macro: ALU_BARREL_SHIFT_EN (defined: single-cycle barrel shifts; undefined: 1 bit/cycle shifts)
module alu_exec_unit #(
  parameter int XLEN    = 32,
  parameter int SHAMT_W = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      alu_ctrl,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            zero,
  output logic            br_taken
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_HOLD  = 2'd2
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;

  logic [XLEN-1:0]      r_result;
  logic                 r_br_taken;
  logic [XLEN-1:0]      r_work;
  logic [SHAMT_W-1:0]   r_count;
  logic [1:0]           r_shift_kind;

  logic                 w_accept;
  logic [SHAMT_W-1:0]   w_amt;
  logic                 w_is_shift;
  logic                 w_start_shift;
  logic                 w_count_last;
  logic [XLEN-1:0]      w_diff;
  logic [XLEN-1:0]      w_alu_res;
  logic                 w_alu_br;
  logic [XLEN-1:0]      w_shift_step;

  assign w_accept     = in_valid && (r_state == ST_IDLE);
  assign w_amt        = op_b[SHAMT_W-1:0];
  assign w_is_shift   = (alu_ctrl == 4'b0101) || (alu_ctrl == 4'b0110) || (alu_ctrl == 4'b0111);
  assign w_diff       = op_a - op_b;
  assign w_count_last = (r_count == SHAMT_W'(1));

`ifdef ALU_BARREL_SHIFT_EN
  assign w_start_shift = 1'b0;
`else
  // A zero-amount shift is just a copy of op_a, so it takes the 1-cycle path.
  assign w_start_shift = w_is_shift && (w_amt != '0);
`endif

  assign in_ready  = (r_state == ST_IDLE);
  assign out_valid = (r_state == ST_HOLD);
  assign result    = r_result;
  assign zero      = (r_result == '0);
  assign br_taken  = r_br_taken;

  // Single-cycle ALU function evaluated on the accept edge operands.
  always_comb begin
    w_alu_res = '0;
    w_alu_br  = 1'b0;
    case (alu_ctrl)
      4'b0000: w_alu_res = op_a + op_b;
      4'b0001: w_alu_res = w_diff;
      4'b0010: w_alu_res = op_a & op_b;
      4'b0011: w_alu_res = op_a | op_b;
      4'b0100: w_alu_res = op_a ^ op_b;
`ifdef ALU_BARREL_SHIFT_EN
      4'b0101: w_alu_res = op_a << w_amt;
      4'b0110: w_alu_res = op_a >> w_amt;
      4'b0111: w_alu_res = $unsigned($signed(op_a) >>> w_amt);
`else
      4'b0101, 4'b0110, 4'b0111: w_alu_res = op_a;
`endif
      4'b1000: begin
        w_alu_res = w_diff;
        w_alu_br  = (op_a == op_b);
      end
      4'b1001: begin
        w_alu_res = w_diff;
        w_alu_br  = (op_a != op_b);
      end
      4'b1010: begin
        w_alu_res = w_diff;
        w_alu_br  = ($signed(op_a) < $signed(op_b));
      end
      4'b1011: begin
        w_alu_res = w_diff;
        w_alu_br  = ($signed(op_a) >= $signed(op_b));
      end
      default: begin
        w_alu_res = '0;
        w_alu_br  = 1'b0;
      end
    endcase
  end

  // One-bit shift of the working register for the iterative shifter.
  always_comb begin
    w_shift_step = r_work;
    case (r_shift_kind)
      2'b01:   w_shift_step = {r_work[XLEN-2:0], 1'b0};
      2'b10:   w_shift_step = {1'b0, r_work[XLEN-1:1]};
      default: w_shift_step = {r_work[XLEN-1], r_work[XLEN-1:1]};
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic: IDLE accepts, SHIFT iterates, HOLD waits for the consumer.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_state_nxt = w_start_shift ? ST_SHIFT : ST_HOLD;
        end
      end
      ST_SHIFT: begin
        if (w_count_last) begin
          w_state_nxt = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (out_ready) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Result and shifter datapath; result/br_taken only change on accept or shift completion.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_result     <= '0;
      r_br_taken   <= 1'b0;
      r_work       <= '0;
      r_count      <= '0;
      r_shift_kind <= 2'b00;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            if (w_start_shift) begin
              r_work       <= op_a;
              r_count      <= w_amt;
              r_shift_kind <= alu_ctrl[1:0];
              r_br_taken   <= 1'b0;
            end else begin
              r_result   <= w_alu_res;
              r_br_taken <= w_alu_br;
            end
          end
        end
        ST_SHIFT: begin
          r_work  <= w_shift_step;
          r_count <= r_count - SHAMT_W'(1);
          if (w_count_last) begin
            r_result   <= w_shift_step;
            r_br_taken <= 1'b0;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule
